pcie_reset_sequencer: RTL and testbench
=======================================

PCIE_RESET_SEQUENCER -- requirements
Module: pcie_reset_sequencer

Interface
- REQ-001: Parameter HOLD_CYCLES, default 1024, SHALL be the number of clk cycles PERST# stays released with MMCM locked before the PCIe core leaves reset (valid range 2..2^20).
- REQ-002: Parameter LINK_TIMEOUT, default 2^20, SHALL be the number of clk cycles allowed for link_up after core release (valid range 2..2^24).
- REQ-003: clk  input  1  free-running system clock; the only clock in the block.
- REQ-004: rstn  input  1  reset, asynchronous assert, active-low.
- REQ-005: pcie_rstn  input  1  PERST# from the slot, asynchronous to clk, active-low.
- REQ-006: board_id  input  3  BOARD_ID straps, quasi-static.
- REQ-007: mmcm_locked  input  1  reference-clock MMCM lock, synchronous to clk.
- REQ-008: link_up  input  1  PCIe core link-up status, synchronous to clk.
- REQ-009: core_rstn  output  1  active-low reset to the PCIe core.
- REQ-010: user_rstn  output  1  active-low reset to user logic behind the core.
- REQ-011: board_id_q  output  3  latched board ID.
- REQ-012: state  output  3  current FSM state encoding.
- REQ-013: link_timeout  output  1  single-cycle pulse on link timeout.
- REQ-014: retry_cnt  output  8  count of link timeouts since rstn.

Function
- REQ-015: pcie_rstn SHALL pass through a 2-flop synchronizer (perst_s), giving 2-cycle latency.
- REQ-016: FSM states SHALL be RESET=0, WAIT_LOCK=1, HOLD=2, CORE_UP=3, RUN=4.
- REQ-017: RESET SHALL go to WAIT_LOCK when perst_s=1, latching board_id into board_id_q on that transition edge.
- REQ-018: WAIT_LOCK SHALL go to HOLD when mmcm_locked=1, clearing the cycle counter.
- REQ-019: HOLD SHALL increment the counter each cycle and go to CORE_UP on the cycle the counter equals HOLD_CYCLES-1, then clear the counter.
- REQ-020: CORE_UP SHALL increment the counter each cycle and go to RUN when link_up=1.
- REQ-021: RUN SHALL return to CORE_UP with the counter cleared when link_up falls.
- REQ-022: perst_s=0 SHALL force RESET on the next edge from any state, with priority over all other transitions.
- REQ-023: mmcm_locked=0 in HOLD, CORE_UP or RUN SHALL force WAIT_LOCK on the next edge.
- REQ-024: core_rstn SHALL be 1 only in CORE_UP and RUN.
- REQ-025: user_rstn SHALL be 1 only in RUN.
- REQ-026: Both reset outputs SHALL be registered and glitch-free.
- REQ-027: The counter SHALL be $clog2(max(HOLD_CYCLES,LINK_TIMEOUT)+1) bits wide and SHALL never wrap.
- REQ-028: When link_up=1 and the timeout condition coincide, link_up SHALL win and the next state is RUN.

Reset
- REQ-029: rstn=0 SHALL asynchronously set state=RESET, core_rstn=0, user_rstn=0, board_id_q=0, link_timeout=0, retry_cnt=0, counter=0 and both synchronizer flops=0.
- REQ-030: Release of rstn mid-sequence SHALL restart from RESET; no state is retained.

Configuration
- REQ-031: With macro PCIE_SEQ_LINK_TIMEOUT_EN defined, CORE_UP reaching counter=LINK_TIMEOUT-1 without link_up SHALL go to RESET and pulse link_timeout for 1 cycle.
- REQ-032: With PCIE_SEQ_LINK_TIMEOUT_EN defined, each timeout SHALL increment retry_cnt, saturating at 255.
- REQ-033: Without PCIE_SEQ_LINK_TIMEOUT_EN, CORE_UP SHALL wait indefinitely with the counter saturating, and link_timeout and retry_cnt SHALL be tied to 0.

Structure
- REQ-034: Package pcie_seq_pkg SHALL hold the state enum typedef (3-bit), the state encodings and the retry_cnt width constant.
- REQ-035: The synchronizer SHALL be sub-module cdc_sync_2ff (1-bit, async active-low reset), instantiated once.

Verification (HOLD_CYCLES=16, LINK_TIMEOUT=64)
- REQ-036: Release rstn, then pcie_rstn, then mmcm_locked=1 -> core_rstn rises exactly 16 cycles after HOLD entry; link_up=1 -> user_rstn=1 next edge, state=4.
- REQ-037: board_id=3'b101 at the RESET exit edge, then changed to 3'b010 -> board_id_q stays 3'b101 until the next RESET exit.
- REQ-038: Drop pcie_rstn in RUN -> state=0, core_rstn=0 and user_rstn=0 within 3 cycles; the sequence restarts on release.
- REQ-039: TIMEOUT_EN on, link_up held 0 -> link_timeout pulses 64 cycles after CORE_UP entry, retry_cnt=1; after 256 timeouts retry_cnt stays 255.
- REQ-040: TIMEOUT_EN off, link_up held 0 for 10000 cycles -> state stays 3 and link_timeout stays 0.
- REQ-041: Deassert mmcm_locked in HOLD at count 8 -> state=1, counter cleared, and a full 16 cycles are required after relock.

Source files
------------

// File: rtl/pcie_seq_pkg.sv
// Shared types and constants for the PCIe reset sequencer.
package pcie_seq_pkg;

    typedef enum logic [2:0] {
        ST_RESET     = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_HOLD      = 3'd2,
        ST_CORE_UP   = 3'd3,
        ST_RUN       = 3'd4
    } seq_state_e;

    localparam int RETRY_W = 8;
    localparam logic [RETRY_W-1:0] RETRY_MAX = {RETRY_W{1'b1}};

endpackage

// File: rtl/cdc_sync_2ff.sv
// Two-flop single-bit synchronizer with asynchronous active-low reset.
module cdc_sync_2ff (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pcie_reset_sequencer.sv
// Sequences PERST#, MMCM lock and link-up into core/user resets.
// Optional link timeout/retry logic is enabled by PCIE_SEQ_LINK_TIMEOUT_EN.
module pcie_reset_sequencer
    import pcie_seq_pkg::*;
#(
    parameter int HOLD_CYCLES  = 1024,
    parameter int LINK_TIMEOUT = 1 << 20
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               pcie_rstn,
    input  logic [2:0]         board_id,
    input  logic               mmcm_locked,
    input  logic               link_up,
    output logic               core_rstn,
    output logic               user_rstn,
    output logic [2:0]         board_id_q,
    output logic [2:0]         state,
    output logic               link_timeout,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int CNT_MAX_VAL = (HOLD_CYCLES > LINK_TIMEOUT) ? HOLD_CYCLES : LINK_TIMEOUT;
    localparam int CNT_W       = $clog2(CNT_MAX_VAL + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_SAT   = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    seq_state_e       cur_state, next_state;
    logic [CNT_W-1:0] cnt, cnt_d;
    logic             perst_s;
    logic             latch_id;
    logic             core_rstn_d, user_rstn_d;

    cdc_sync_2ff u_perst_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (pcie_rstn),
        .q    (perst_s)
    );

    // State register; reset outputs are registered from next_state so they
    // change on the same edge as the state and never glitch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_state  <= ST_RESET;
            cnt        <= '0;
            core_rstn  <= 1'b0;
            user_rstn  <= 1'b0;
            board_id_q <= '0;
        end else begin
            cur_state <= next_state;
            cnt       <= cnt_d;
            core_rstn <= core_rstn_d;
            user_rstn <= user_rstn_d;
            if (latch_id) begin
                board_id_q <= board_id;
            end
        end
    end

`ifdef PCIE_SEQ_LINK_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LINK_TIMEOUT - 1);
    logic timeout_hit;
`endif

    always_comb begin
        next_state = cur_state;
        cnt_d      = cnt;
        latch_id   = 1'b0;
`ifdef PCIE_SEQ_LINK_TIMEOUT_EN
        timeout_hit = 1'b0;
`endif
        if (!perst_s) begin
            next_state = ST_RESET;
            cnt_d      = '0;
        end else if (!mmcm_locked &&
                     (cur_state == ST_HOLD || cur_state == ST_CORE_UP || cur_state == ST_RUN)) begin
            next_state = ST_WAIT_LOCK;
            cnt_d      = '0;
        end else begin
            case (cur_state)
                ST_RESET: begin
                    next_state = ST_WAIT_LOCK;
                    cnt_d      = '0;
                    latch_id   = 1'b1;
                end
                ST_WAIT_LOCK: begin
                    cnt_d = '0;
                    if (mmcm_locked) begin
                        next_state = ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (cnt == HOLD_LAST) begin
                        next_state = ST_CORE_UP;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt + CNT_ONE;
                    end
                end
                ST_CORE_UP: begin
                    if (cnt != CNT_SAT) begin
                        cnt_d = cnt + CNT_ONE;
                    end
                    // link_up wins over a coincident timeout
                    if (link_up) begin
                        next_state = ST_RUN;
                    end
`ifdef PCIE_SEQ_LINK_TIMEOUT_EN
                    else if (cnt == TIMEOUT_LAST) begin
                        next_state  = ST_RESET;
                        cnt_d       = '0;
                        timeout_hit = 1'b1;
                    end
`endif
                end
                ST_RUN: begin
                    if (!link_up) begin
                        next_state = ST_CORE_UP;
                        cnt_d      = '0;
                    end
                end
                default: begin
                    next_state = ST_RESET;
                    cnt_d      = '0;
                end
            endcase
        end
    end

    always_comb begin
        core_rstn_d = (next_state == ST_CORE_UP) || (next_state == ST_RUN);
        user_rstn_d = (next_state == ST_RUN);
    end

    assign state = cur_state;

`ifdef PCIE_SEQ_LINK_TIMEOUT_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            link_timeout <= 1'b0;
            retry_cnt    <= '0;
        end else begin
            link_timeout <= timeout_hit;
            if (timeout_hit && retry_cnt != RETRY_MAX) begin
                retry_cnt <= retry_cnt + RETRY_W'(1);
            end
        end
    end
`else
    assign link_timeout = 1'b0;
    assign retry_cnt    = '0;
`endif

endmodule

// File: tb/tb_pcie_reset_sequencer.sv
// Randomized bench for pcie_reset_sequencer with HOLD_CYCLES=16, LINK_TIMEOUT=64.
module tb_pcie_reset_sequencer;

    localparam int HOLD     = 16;
    localparam int LINK     = 64;
    localparam int SYNC_LAT = 2;

    logic       clk = 1'b0;
    logic       rstn, pcie_rstn, mmcm_locked, link_up;
    logic [2:0] board_id, board_id_q, state;
    logic       core_rstn, user_rstn, link_timeout;
    logic [7:0] retry_cnt;

    int vectors     = 0;
    int miscompares = 0;

    // reference model: latched id and number of timeouts seen (saturating)
    logic [2:0] exp_board_id;
    int         exp_retry;

    always #5 clk = ~clk;

    pcie_reset_sequencer #(.HOLD_CYCLES(HOLD), .LINK_TIMEOUT(LINK)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .pcie_rstn    (pcie_rstn),
        .board_id     (board_id),
        .mmcm_locked  (mmcm_locked),
        .link_up      (link_up),
        .core_rstn    (core_rstn),
        .user_rstn    (user_rstn),
        .board_id_q   (board_id_q),
        .state        (state),
        .link_timeout (link_timeout),
        .retry_cnt    (retry_cnt)
    );

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // counts edges until core_rstn rises, bounded
    task automatic cycles_to_core_up(output int n);
        n = 0;
        while (core_rstn !== 1'b1 && n < HOLD + 8) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0; pcie_rstn = 1'b0; mmcm_locked = 1'b0; link_up = 1'b0;
        board_id = 3'($urandom_range(0, 7));
        exp_board_id = 3'd0; exp_retry = 0;
        step(3);
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL reset_state: got %0d expected 0", state); end
        vectors++; if (core_rstn !== 1'b0) begin miscompares++; $display("FAIL reset_core_rstn: got %b expected 0", core_rstn); end
        vectors++; if (user_rstn !== 1'b0) begin miscompares++; $display("FAIL reset_user_rstn: got %b expected 0", user_rstn); end
        vectors++; if (board_id_q !== exp_board_id) begin miscompares++; $display("FAIL reset_board_id_q: got %0d expected %0d", board_id_q, exp_board_id); end
        vectors++; if (link_timeout !== 1'b0) begin miscompares++; $display("FAIL reset_link_timeout: got %b expected 0", link_timeout); end
        vectors++; if (retry_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_retry_cnt: got %0d expected 0", retry_cnt); end
    endtask

    task automatic test_bringup();
        int n, d;
        rstn = 1'b1;
        step(2);
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL perst_held_state: got %0d expected 0", state); end
        board_id = 3'b101; pcie_rstn = 1'b1;
        step(SYNC_LAT);
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL sync_latency_state: got %0d expected 0", state); end
        step();
        exp_board_id = 3'b101;
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL wait_lock_entry: got %0d expected 1", state); end
        vectors++; if (board_id_q !== exp_board_id) begin miscompares++; $display("FAIL board_id_latch: got %0d expected %0d", board_id_q, exp_board_id); end
        board_id = 3'b010;
        step(3);
        vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL wait_lock_hold: got %0d expected 1", state); end
        mmcm_locked = 1'b1;
        step();
        vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL hold_entry: got %0d expected 2", state); end
        cycles_to_core_up(n);
        vectors++; if (n !== HOLD) begin miscompares++; $display("FAIL hold_length: got %0d expected %0d", n, HOLD); end
        vectors++; if (state !== 3'd3 || user_rstn !== 1'b0) begin miscompares++; $display("FAIL core_up_state: got %0d/%b expected 3/0", state, user_rstn); end
        vectors++; if (board_id_q !== exp_board_id) begin miscompares++; $display("FAIL board_id_stable: got %0d expected %0d", board_id_q, exp_board_id); end
        d = $urandom_range(0, 40);
        step(d);
        vectors++; if (state !== 3'd3 || core_rstn !== 1'b1) begin miscompares++; $display("FAIL core_up_wait: got %0d/%b expected 3/1", state, core_rstn); end
        link_up = 1'b1;
        step();
        vectors++; if (state !== 3'd4 || user_rstn !== 1'b1 || core_rstn !== 1'b1) begin
            miscompares++; $display("FAIL run_entry: got state %0d user %b core %b expected 4/1/1", state, user_rstn, core_rstn);
        end
    endtask

    task automatic test_link_flap();
        int gap;
        for (int i = 0; i < 4; i++) begin
            link_up = 1'b0;
            step();
            vectors++; if (state !== 3'd3 || user_rstn !== 1'b0 || core_rstn !== 1'b1) begin
                miscompares++; $display("FAIL flap_down_%0d: got state %0d user %b core %b expected 3/0/1", i, state, user_rstn, core_rstn);
            end
            gap = $urandom_range(0, 40);
            step(gap);
            link_up = 1'b1;
            step();
            vectors++; if (state !== 3'd4 || user_rstn !== 1'b1) begin
                miscompares++; $display("FAIL flap_up_%0d: got state %0d user %b expected 4/1", i, state, user_rstn);
            end
        end
    endtask

    task automatic test_perst_drop();
        pcie_rstn = 1'b0;
        step(SYNC_LAT);
        vectors++; if (state !== 3'd4) begin miscompares++; $display("FAIL perst_drop_early: got %0d expected 4", state); end
        step();
        vectors++; if (state !== 3'd0 || core_rstn !== 1'b0 || user_rstn !== 1'b0) begin
            miscompares++; $display("FAIL perst_drop: got state %0d core %b user %b expected 0/0/0", state, core_rstn, user_rstn);
        end
        board_id = 3'($urandom_range(0, 7));
        exp_board_id = board_id;
        pcie_rstn = 1'b1;
        step(SYNC_LAT + 1);
        vectors++; if (state !== 3'd1 || board_id_q !== exp_board_id) begin
            miscompares++; $display("FAIL perst_restart: got state %0d id %0d expected 1/%0d", state, board_id_q, exp_board_id);
        end
        board_id = ~board_id;
        step();
        vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL perst_restart_hold: got %0d expected 2", state); end
        step(HOLD);
        vectors++; if (state !== 3'd3 || core_rstn !== 1'b1) begin miscompares++; $display("FAIL perst_restart_core: got %0d/%b expected 3/1", state, core_rstn); end
        step();
        vectors++; if (state !== 3'd4 || board_id_q !== exp_board_id) begin
            miscompares++; $display("FAIL perst_restart_run: got state %0d id %0d expected 4/%0d", state, board_id_q, exp_board_id);
        end
    endtask

    task automatic test_lock_drop();
        int n, k;
        mmcm_locked = 1'b0;
        step();
        vectors++; if (state !== 3'd1 || core_rstn !== 1'b0 || user_rstn !== 1'b0) begin
            miscompares++; $display("FAIL lock_drop_run: got state %0d core %b user %b expected 1/0/0", state, core_rstn, user_rstn);
        end
        link_up = 1'b0;
        for (int i = 0; i < 3; i++) begin
            k = (i == 0) ? 8 : $urandom_range(1, HOLD - 1);
            mmcm_locked = 1'b1;
            step();
            vectors++; if (state !== 3'd2) begin miscompares++; $display("FAIL relock_hold_%0d: got %0d expected 2", i, state); end
            step(k);
            mmcm_locked = 1'b0;
            step();
            vectors++; if (state !== 3'd1) begin miscompares++; $display("FAIL lock_drop_hold_%0d: got %0d expected 1", i, state); end
        end
        mmcm_locked = 1'b1;
        step();
        cycles_to_core_up(n);
        vectors++; if (n !== HOLD) begin miscompares++; $display("FAIL relock_full_hold: got %0d expected %0d", n, HOLD); end
    endtask

`ifdef PCIE_SEQ_LINK_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        // link_up arriving on the very last allowed cycle still wins
        step(LINK - 1);
        vectors++; if (state !== 3'd3 || link_timeout !== 1'b0) begin miscompares++; $display("FAIL pre_timeout: got %0d/%b expected 3/0", state, link_timeout); end
        link_up = 1'b1;
        step();
        vectors++; if (state !== 3'd4 || link_timeout !== 1'b0 || retry_cnt !== 8'(exp_retry)) begin
            miscompares++; $display("FAIL link_beats_timeout: got state %0d lt %b retry %0d expected 4/0/%0d", state, link_timeout, retry_cnt, exp_retry);
        end
        link_up = 1'b0;
        step();
        n = 0;
        while (link_timeout !== 1'b1 && n < LINK + 8) begin
            step();
            n++;
        end
        exp_retry = 1;
        vectors++; if (n !== LINK) begin miscompares++; $display("FAIL timeout_latency: got %0d expected %0d", n, LINK); end
        vectors++; if (state !== 3'd0 || retry_cnt !== 8'(exp_retry) || core_rstn !== 1'b0) begin
            miscompares++; $display("FAIL timeout_state: got state %0d retry %0d core %b expected 0/%0d/0", state, retry_cnt, core_rstn, exp_retry);
        end
        step();
        vectors++; if (link_timeout !== 1'b0) begin miscompares++; $display("FAIL timeout_pulse_width: got %b expected 0", link_timeout); end
        for (int t = 2; t <= 258; t++) begin
            n = 0;
            while (link_timeout !== 1'b1 && n < 200) begin
                step();
                n++;
            end
            exp_retry = (exp_retry < 255) ? exp_retry + 1 : 255;
            vectors++; if (link_timeout !== 1'b1 || retry_cnt !== 8'(exp_retry)) begin
                miscompares++; $display("FAIL retry_%0d: got lt %b retry %0d expected 1/%0d", t, link_timeout, retry_cnt, exp_retry);
            end
            step();
        end
    endtask
`else
    task automatic test_no_timeout();
        int bad;
        bad = 0;
        for (int i = 0; i < 10000; i++) begin
            step();
            vectors++; if (state !== 3'd3 || link_timeout !== 1'b0 || retry_cnt !== 8'd0) begin
                miscompares++;
                if (bad < 5) $display("FAIL no_timeout_cycle_%0d: got state %0d lt %b retry %0d expected 3/0/0", i, state, link_timeout, retry_cnt);
                bad++;
            end
        end
    endtask
`endif

    task automatic test_async_reset();
        int n;
        link_up = 1'b1;
        n = 0;
        while (state !== 3'd4 && n < 300) begin
            step();
            n++;
        end
        vectors++; if (state !== 3'd4) begin miscompares++; $display("FAIL reach_run: got %0d expected 4", state); end
        rstn = 1'b0;
        #2;
        vectors++; if (state !== 3'd0 || core_rstn !== 1'b0 || user_rstn !== 1'b0 || board_id_q !== 3'd0 || retry_cnt !== 8'd0) begin
            miscompares++; $display("FAIL async_reset: got state %0d core %b user %b id %0d retry %0d expected all 0", state, core_rstn, user_rstn, board_id_q, retry_cnt);
        end
        step();
        board_id = 3'($urandom_range(0, 7));
        exp_board_id = board_id;
        rstn = 1'b1;
        step(SYNC_LAT);
        vectors++; if (state !== 3'd0) begin miscompares++; $display("FAIL restart_sync: got %0d expected 0", state); end
        step();
        vectors++; if (state !== 3'd1 || board_id_q !== exp_board_id) begin
            miscompares++; $display("FAIL restart_wait_lock: got state %0d id %0d expected 1/%0d", state, board_id_q, exp_board_id);
        end
    endtask

    initial begin
        test_reset();
        test_bringup();
        test_link_flap();
        test_perst_drop();
        test_lock_drop();
`ifdef PCIE_SEQ_LINK_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
